// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet fire scheduler.
package bullet_pkg;

  // Player facing as reported by the movement logic.
  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    UP    = 2'b11
  } dir_t;

  // Fire sequencing states.
  typedef enum logic [1:0] {
    READY        = 2'b00,
    COOLDOWN     = 2'b01,
    WAIT_RELEASE = 2'b10
  } fire_state_t;

  // Spacebar keycode from the keyboard decoder.
  localparam logic [7:0] KEY_SPACE = 8'd44;

  // Shot counter step; the 8-bit result wraps 255 -> 0 naturally.
  function automatic logic [7:0] wrap_inc8(input logic [7:0] value);
    return value + 8'd1;
  endfunction

endpackage

// File: rtl/lowest_free_encoder.sv
// Combinational priority encoder: picks the lowest-index free slot.
module lowest_free_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] free_i,
  output logic [N-1:0] grant_o,
  output logic         any_free_o
);

  logic seen_s;

  // Walk from slot 0 upward; the first free slot masks all higher ones.
  always_comb begin
    grant_o = '0;
    seen_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      grant_o[k] = free_i[k] & ~seen_s;
      seen_s     = seen_s | free_i[k];
    end
    any_free_o = seen_s;
  end

endmodule

// File: rtl/bullet_fire_scheduler.sv
// Fire sequencer for one player's bullet slots: key edge/hold handling,
// inter-shot cooldown, upgrade timer, slot allocation and shot counting.
module bullet_fire_scheduler
  import bullet_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned UPGRADE_FRAMES  = 600,
  parameter logic [7:0]  FIRE_KEY        = KEY_SPACE
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  input  logic [1:0]           direction,
  input  logic                 upgrade_pickup,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [1:0]           launch_dir,
  output logic                 upgraded,
  output logic                 cooldown_busy,
  output logic [7:0]           shots_fired
);

  localparam int unsigned CNT_W = $clog2(COOLDOWN_FRAMES);
  localparam int unsigned TMR_W = $clog2(UPGRADE_FRAMES + 1);

  // Cooldown reload values: the state lasts reload+1 frames.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(COOLDOWN_FRAMES / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(UPGRADE_FRAMES);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO = TMR_W'(0);

  fire_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [NUM_SLOTS-1:0] slot_active_q, slot_active_d;
  logic [NUM_SLOTS-1:0] launch_q, launch_d;
  dir_t                 launch_dir_q, launch_dir_d;
  logic                 upgraded_q, upgraded_d;
  logic                 cooldown_busy_q, cooldown_busy_d;
  logic [7:0]           shots_q, shots_d;

  logic                 fire_s;
  logic [NUM_SLOTS-1:0] grant_s;
  logic                 any_free_s;

  assign fire_s = (keycode == FIRE_KEY);

  // Allocation looks only at slots in flight before this edge, so a slot
  // retiring on the same edge cannot be reused until the next frame.
  lowest_free_encoder #(
    .N (NUM_SLOTS)
  ) u_free_enc (
    .free_i     (~slot_active_q),
    .grant_o    (grant_s),
    .any_free_o (any_free_s)
  );

  // Fire FSM: launch decision, cooldown countdown and key-release gating.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    launch_d     = '0;
    launch_dir_d = launch_dir_q;
    shots_d      = shots_q;
    case (state_q)
      READY: begin
        if (fire_s) begin
          if (any_free_s) begin
            launch_d     = grant_s;
            launch_dir_d = dir_t'(direction);
            cnt_d        = upgraded_q ? CNT_HALF : CNT_FULL;
            shots_d      = wrap_inc8(shots_q);
            state_d      = COOLDOWN;
          end else begin
            // No free slot: the press is dropped, not queued.
            state_d = WAIT_RELEASE;
          end
        end else begin
          state_d = READY;
        end
      end
      COOLDOWN: begin
        if (cnt_q == CNT_ZERO) begin
          // A key still down when cooldown ends must be released first.
          state_d = fire_s ? WAIT_RELEASE : READY;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (!fire_s) begin
          state_d = READY;
        end else begin
          state_d = WAIT_RELEASE;
        end
      end
      default: begin
        state_d = READY;
        cnt_d   = CNT_ZERO;
      end
    endcase
    cooldown_busy_d = (state_d == COOLDOWN);
  end

  // Slot occupancy: retire on slot_done, occupy on launch.
  always_comb begin
    slot_active_d = (slot_active_q & ~slot_done) | launch_d;
  end

  // Upgrade timer: a pickup restarts the full duration, otherwise count down to zero.
  always_comb begin
    if (upgrade_pickup) begin
      timer_d = TMR_LOAD;
    end else if (timer_q != TMR_ZERO) begin
      timer_d = timer_q - TMR_ONE;
    end else begin
      timer_d = timer_q;
    end
    upgraded_d = (timer_d != TMR_ZERO);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q         <= READY;
      cnt_q           <= CNT_ZERO;
      timer_q         <= TMR_ZERO;
      slot_active_q   <= '0;
      launch_q        <= '0;
      launch_dir_q    <= LEFT;
      upgraded_q      <= 1'b0;
      cooldown_busy_q <= 1'b0;
      shots_q         <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      timer_q         <= timer_d;
      slot_active_q   <= slot_active_d;
      launch_q        <= launch_d;
      launch_dir_q    <= launch_dir_d;
      upgraded_q      <= upgraded_d;
      cooldown_busy_q <= cooldown_busy_d;
      shots_q         <= shots_d;
    end
  end

  assign slot_active   = slot_active_q;
  assign launch        = launch_q;
  assign launch_dir    = launch_dir_q;
  assign upgraded      = upgraded_q;
  assign cooldown_busy = cooldown_busy_q;
  assign shots_fired   = shots_q;

endmodule

// File: tb/tb_bullet_fire_scheduler.sv
// Self-checking bench for bullet_fire_scheduler with a timestamp-based reference model.
module tb_bullet_fire_scheduler;
  import bullet_pkg::*;

  localparam int NS   = 4;
  localparam int CD   = 8;
  localparam int UP_F = 600;

  logic          frame_clk;
  logic          Reset;
  logic [7:0]    keycode;
  logic [1:0]    direction;
  logic          upgrade_pickup;
  logic [NS-1:0] slot_done;
  logic [NS-1:0] slot_active;
  logic [NS-1:0] launch;
  logic [1:0]    launch_dir;
  logic          upgraded;
  logic          cooldown_busy;
  logic [7:0]    shots_fired;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame-number bookkeeping rather than an FSM.
  int            m_frame;
  int            m_last_launch;
  int            m_dur;
  int            m_upg_until;
  int            m_shots;
  bit            m_launched;
  bit            m_need_release;
  logic [NS-1:0] m_active;
  logic [NS-1:0] m_launch;
  logic [1:0]    m_dir;

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  bullet_fire_scheduler #(
    .NUM_SLOTS       (NS),
    .COOLDOWN_FRAMES (CD),
    .UPGRADE_FRAMES  (UP_F),
    .FIRE_KEY        (KEY_SPACE)
  ) dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .direction      (direction),
    .upgrade_pickup (upgrade_pickup),
    .slot_done      (slot_done),
    .slot_active    (slot_active),
    .launch         (launch),
    .launch_dir     (launch_dir),
    .upgraded       (upgraded),
    .cooldown_busy  (cooldown_busy),
    .shots_fired    (shots_fired)
  );

  function automatic logic exp_upgraded();
    return (m_frame < m_upg_until);
  endfunction

  function automatic logic exp_busy();
    return m_launched && (m_frame >= m_last_launch) && (m_frame < m_last_launch + m_dur);
  endfunction

  task automatic model_reset();
    m_frame = 0; m_last_launch = 0; m_dur = 0; m_upg_until = 0; m_shots = 0;
    m_launched = 1'b0; m_need_release = 1'b0;
    m_active = '0; m_launch = '0; m_dir = 2'b00;
  endtask

  // Advance the model by one frame using the current inputs, then clock the DUT.
  task automatic tick();
    int   e;
    bit   fire, upg_before, in_cd, found;
    e          = m_frame + 1;
    fire       = (keycode == KEY_SPACE);
    upg_before = (m_frame < m_upg_until);
    in_cd      = m_launched && (e > m_last_launch) && (e <= m_last_launch + m_dur);
    m_launch   = '0;
    if (in_cd) begin
      if (e == m_last_launch + m_dur && fire) m_need_release = 1'b1;
    end else if (m_need_release) begin
      if (!fire) m_need_release = 1'b0;
    end else if (fire) begin
      found = 1'b0;
      for (int k = 0; k < NS; k++) begin
        if (!found && !m_active[k]) begin
          m_launch[k] = 1'b1;
          found = 1'b1;
        end
      end
      if (found) begin
        m_last_launch = e;
        m_dur         = upg_before ? CD / 2 : CD;
        m_launched    = 1'b1;
        m_dir         = direction;
        m_shots       = (m_shots + 1) % 256;
      end else begin
        m_need_release = 1'b1;
      end
    end
    for (int k = 0; k < NS; k++) begin
      if (slot_done[k]) m_active[k] = 1'b0;
      if (m_launch[k])  m_active[k] = 1'b1;
    end
    if (upgrade_pickup) m_upg_until = e + UP_F;
    m_frame = e;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1; keycode = 8'd0; direction = 2'b00; upgrade_pickup = 1'b0; slot_done = '0;
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    Reset = 1'b1; keycode = KEY_SPACE; direction = 2'b11; upgrade_pickup = 1'b1; slot_done = '1;
    @(posedge frame_clk); #1;
    checks++; if (launch !== 4'b0000) begin failures++; $display("FAIL reset_launch got=%b exp=0000", launch); end
    checks++; if (slot_active !== 4'b0000) begin failures++; $display("FAIL reset_active got=%b exp=0000", slot_active); end
    checks++; if (launch_dir !== 2'b00) begin failures++; $display("FAIL reset_dir got=%b exp=00", launch_dir); end
    checks++; if (upgraded !== 1'b0) begin failures++; $display("FAIL reset_upgraded got=%b exp=0", upgraded); end
    checks++; if (cooldown_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", cooldown_busy); end
    checks++; if (shots_fired !== 8'd0) begin failures++; $display("FAIL reset_shots got=%0d exp=0", shots_fired); end
    apply_reset();
  endtask

  task automatic test_hold_fire();
    logic [1:0] d0;
    apply_reset();
    tick();
    keycode = KEY_SPACE; d0 = 2'($urandom_range(0, 3)); direction = d0;
    tick();
    checks++; if (launch !== 4'b0001) begin failures++; $display("FAIL hold_first_launch got=%b exp=0001", launch); end
    checks++; if (launch_dir !== d0) begin failures++; $display("FAIL hold_dir got=%b exp=%b", launch_dir, d0); end
    for (int i = 0; i < 20; i++) begin
      direction = 2'($urandom_range(0, 3));
      tick();
      checks++; if (launch !== 4'b0000) begin failures++; $display("FAIL hold_repeat frame=%0d got=%b exp=0000", m_frame, launch); end
      checks++; if (launch_dir !== d0) begin failures++; $display("FAIL hold_dir_kept frame=%0d got=%b exp=%b", m_frame, launch_dir, d0); end
      checks++; if (cooldown_busy !== exp_busy()) begin failures++; $display("FAIL hold_busy frame=%0d got=%b exp=%b", m_frame, cooldown_busy, exp_busy()); end
    end
    keycode = 8'd0; tick();
    checks++; if (launch !== 4'b0000) begin failures++; $display("FAIL hold_release got=%b exp=0000", launch); end
    keycode = KEY_SPACE; tick();
    checks++; if (launch !== 4'b0010 || launch !== m_launch) begin failures++; $display("FAIL hold_relaunch got=%b exp=0010", launch); end
    keycode = 8'd0; tick();
  endtask

  task automatic test_fill_slots();
    logic [3:0] exp_l [5];
    exp_l[0] = 4'b0001; exp_l[1] = 4'b0010; exp_l[2] = 4'b0100; exp_l[3] = 4'b1000; exp_l[4] = 4'b0000;
    apply_reset();
    // Taps spaced one frame past the end of cooldown so each is a fresh press.
    for (int i = 0; i < 5; i++) begin
      keycode = KEY_SPACE; tick();
      checks++; if (launch !== exp_l[i] || launch !== m_launch) begin failures++; $display("FAIL fill_launch tap=%0d got=%b exp=%b", i, launch, exp_l[i]); end
      checks++; if (slot_active !== m_active) begin failures++; $display("FAIL fill_active tap=%0d got=%b exp=%b", i, slot_active, m_active); end
      if (i < 4) begin
        keycode = 8'd0;
        for (int f = 0; f < CD; f++) begin
          tick();
          checks++; if (cooldown_busy !== exp_busy()) begin failures++; $display("FAIL fill_busy frame=%0d got=%b exp=%b", m_frame, cooldown_busy, exp_busy()); end
        end
      end
    end
    // Still held: a slot frees up but the dropped press must not launch.
    slot_done = 4'b0001; tick(); slot_done = '0;
    repeat (3) begin
      tick();
      checks++; if (launch !== 4'b0000) begin failures++; $display("FAIL fill_wait_release frame=%0d got=%b exp=0000", m_frame, launch); end
    end
    keycode = 8'd0; tick();
    keycode = KEY_SPACE; tick();
    checks++; if (launch !== 4'b0001) begin failures++; $display("FAIL fill_after_release got=%b exp=0001", launch); end
    keycode = 8'd0; tick();
  endtask

  task automatic test_same_edge_retire();
    apply_reset();
    for (int i = 0; i < NS; i++) begin
      keycode = KEY_SPACE; tick();
      keycode = 8'd0; repeat (CD) tick();
    end
    checks++; if (slot_active !== 4'b1111) begin failures++; $display("FAIL retire_full got=%b exp=1111", slot_active); end
    keycode = KEY_SPACE; slot_done = 4'b0100; tick();
    checks++; if (launch !== 4'b0000) begin failures++; $display("FAIL retire_same_edge got=%b exp=0000", launch); end
    checks++; if (slot_active !== 4'b1011) begin failures++; $display("FAIL retire_cleared got=%b exp=1011", slot_active); end
    // The failed press parks the FSM until release; release then retry.
    keycode = 8'd0; slot_done = '0; tick();
    keycode = KEY_SPACE; tick();
    checks++; if (launch !== 4'b0100 || launch !== m_launch) begin failures++; $display("FAIL retire_retry got=%b exp=0100", launch); end
    checks++; if (slot_active !== 4'b1111) begin failures++; $display("FAIL retire_refill got=%b exp=1111", slot_active); end
    keycode = 8'd0; tick();
  endtask

  task automatic test_upgrade();
    int busy_frames, p, drop;
    bit dropped;
    apply_reset();
    upgrade_pickup = 1'b1; tick(); upgrade_pickup = 1'b0; p = m_frame;
    checks++; if (upgraded !== 1'b1) begin failures++; $display("FAIL upg_set got=%b exp=1", upgraded); end
    keycode = KEY_SPACE; tick(); keycode = 8'd0;
    checks++; if (launch !== 4'b0001) begin failures++; $display("FAIL upg_launch1 got=%b exp=0001", launch); end
    busy_frames = cooldown_busy ? 1 : 0;
    for (int f = 0; f < 20; f++) begin
      tick();
      if (!cooldown_busy) break;
      busy_frames++;
    end
    checks++; if (busy_frames !== CD / 2) begin failures++; $display("FAIL upg_busy_len got=%0d exp=%0d", busy_frames, CD / 2); end
    keycode = KEY_SPACE; tick(); keycode = 8'd0;
    checks++; if (launch !== 4'b0010) begin failures++; $display("FAIL upg_launch2 got=%b exp=0010", launch); end
    dropped = 1'b0; drop = 0;
    for (int f = 0; f < UP_F + 100 && !dropped; f++) begin
      tick();
      checks++; if (upgraded !== exp_upgraded()) begin failures++; $display("FAIL upg_track frame=%0d got=%b exp=%b", m_frame, upgraded, exp_upgraded()); end
      if (!upgraded) begin dropped = 1'b1; drop = m_frame; end
    end
    checks++; if (!dropped || drop - p !== UP_F) begin failures++; $display("FAIL upg_expiry got=%0d exp=%0d", drop - p, UP_F); end
    // Pickup on the very edge the timer would expire.
    upgrade_pickup = 1'b1; tick(); upgrade_pickup = 1'b0;
    repeat (UP_F - 1) tick();
    upgrade_pickup = 1'b1; tick(); upgrade_pickup = 1'b0;
    checks++; if (upgraded !== 1'b1) begin failures++; $display("FAIL upg_expiry_pickup got=%b exp=1", upgraded); end
    // Re-pickup part way through pushes expiry out.
    repeat (UP_F / 2 - 1) tick();
    upgrade_pickup = 1'b1; tick(); upgrade_pickup = 1'b0; p = m_frame;
    dropped = 1'b0; drop = 0;
    for (int f = 0; f < UP_F + 100 && !dropped; f++) begin
      tick();
      checks++; if (upgraded !== exp_upgraded()) begin failures++; $display("FAIL upg_track2 frame=%0d got=%b exp=%b", m_frame, upgraded, exp_upgraded()); end
      if (!upgraded) begin dropped = 1'b1; drop = m_frame; end
    end
    checks++; if (!dropped || drop - p !== UP_F) begin failures++; $display("FAIL upg_restart_expiry got=%0d exp=%0d", drop - p, UP_F); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      keycode = KEY_SPACE; tick();
      keycode = 8'd0;
      if (i < 2) repeat (CD) tick(); else repeat (2) tick();
    end
    checks++; if (slot_active !== 4'b0111 || cooldown_busy !== 1'b1) begin failures++; $display("FAIL areset_pre active=%b busy=%b exp=0111/1", slot_active, cooldown_busy); end
    #2; Reset = 1'b1; #1;
    checks++; if ({slot_active, launch, launch_dir, upgraded, cooldown_busy} !== 12'd0) begin failures++; $display("FAIL areset_outputs got=%b exp=0", {slot_active, launch, launch_dir, upgraded, cooldown_busy}); end
    checks++; if (shots_fired !== 8'd0) begin failures++; $display("FAIL areset_shots got=%0d exp=0", shots_fired); end
    @(negedge frame_clk); Reset = 1'b0; model_reset();
    keycode = KEY_SPACE; tick(); keycode = 8'd0;
    checks++; if (launch !== 4'b0001 || shots_fired !== 8'd1) begin failures++; $display("FAIL areset_ready launch=%b shots=%0d exp=0001/1", launch, shots_fired); end
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    keycode = KEY_SPACE; tick(); keycode = 8'd0;
    slot_done = 4'b1110; tick();
    checks++; if (slot_active !== 4'b0001) begin failures++; $display("FAIL wrap_inactive_done got=%b exp=0001", slot_active); end
    slot_done = 4'b0001; tick(); slot_done = '0;
    repeat (CD - 2) tick();
    for (int n = 2; n <= 256; n++) begin
      keycode = KEY_SPACE; tick(); keycode = 8'd0;
      checks++; if (launch !== 4'b0001 || shots_fired !== 8'(m_shots)) begin failures++; $display("FAIL wrap_launch n=%0d launch=%b shots=%0d exp=0001/%0d", n, launch, shots_fired, m_shots); end
      slot_done = 4'b1111; tick(); slot_done = '0;
      repeat (CD - 1) tick();
    end
    checks++; if (shots_fired !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", shots_fired); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      keycode        = ($urandom_range(0, 9) < 4) ? KEY_SPACE : 8'($urandom_range(0, 255));
      direction      = 2'($urandom_range(0, 3));
      upgrade_pickup = ($urandom_range(0, 249) == 0);
      slot_done      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      tick();
      checks++;
      if (launch !== m_launch || slot_active !== m_active || launch_dir !== m_dir ||
          upgraded !== exp_upgraded() || cooldown_busy !== exp_busy() || shots_fired !== 8'(m_shots)) begin
        failures++;
        $display("FAIL random frame=%0d got l=%b a=%b d=%b u=%b b=%b s=%0d exp l=%b a=%b d=%b u=%b b=%b s=%0d",
                 m_frame, launch, slot_active, launch_dir, upgraded, cooldown_busy, shots_fired,
                 m_launch, m_active, m_dir, exp_upgraded(), exp_busy(), m_shots);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; keycode = 8'd0; direction = 2'b00; upgrade_pickup = 1'b0; slot_done = '0;
    model_reset();
    test_reset();
    test_hold_fire();
    test_fill_slots();
    test_same_edge_retire();
    test_upgrade();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
